// File: rtl/config_pkg.sv
// Core-wide configuration constants shared by the pipeline stages.
package config_pkg;
  localparam int XLEN = 32;
  localparam int ILEN = 32;
endpackage

// File: rtl/instruction_pkg.sv
// Instruction-level types for the RV32 pipeline: fetched/decoded bundles,
// ALU operation codes and base opcode constants.
package instruction_pkg;
  import config_pkg::*;

  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;

  // M-extension ops sit at 16 + funct3 so they can be formed directly.
  typedef enum logic [4:0] {
    ALU_ADD = 5'd0, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR,
    ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_COPY_B,
    ALU_MUL = 5'd16, ALU_MULH, ALU_MULHSU, ALU_MULHU,
    ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU
  } alu_op_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
  } inst_fetched_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] imm;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [2:0]      funct3;   // also the memory access width
    alu_op_e         alu_op;
    logic            reg_write;
    logic            mem_read;
    logic            mem_write;
    logic            branch;
    logic            jump;
    logic            uses_rs1;
    logic            uses_rs2;
    logic            is_system;
    logic            illegal;
  } decoded_inst_t;

  // Integer ALU op from funct3; alt selects SUB/SRA (instr[30]).
  function automatic alu_op_e alu_from_f3(input logic [2:0] f3, input logic alt);
    case (f3)
      3'd0:    return alt ? ALU_SUB : ALU_ADD;
      3'd1:    return ALU_SLL;
      3'd2:    return ALU_SLT;
      3'd3:    return ALU_SLTU;
      3'd4:    return ALU_XOR;
      3'd5:    return alt ? ALU_SRA : ALU_SRL;
      3'd6:    return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction
endpackage

// File: rtl/decode_stage_rv_decoder.sv
// Purely combinational RV32I decoder. Optional M extension is enabled by
// defining DECODE_RV32M_EN; otherwise those encodings decode as illegal.
module rv_decoder
  import config_pkg::*;
  import instruction_pkg::*;
(
  input  logic [ILEN-1:0] instr_i,
  input  logic [XLEN-1:0] pc_i,
  output decoded_inst_t   dec_o
);
  logic [6:0]      opc, f7;
  logic [2:0]      f3;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic            legal;

  assign opc = instr_i[6:0];
  assign f3  = instr_i[14:12];
  assign f7  = instr_i[31:25];

  assign imm_i = {{20{instr_i[31]}}, instr_i[31:20]};
  assign imm_s = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
  assign imm_b = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
  assign imm_u = {instr_i[31:12], 12'b0};
  assign imm_j = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};

  // Field extraction, per-opcode control and legality, then illegal/x0 masking.
  always_comb begin
    dec_o        = '0;
    dec_o.pc     = pc_i;
    dec_o.rd     = instr_i[11:7];
    dec_o.rs1    = instr_i[19:15];
    dec_o.rs2    = instr_i[24:20];
    dec_o.funct3 = f3;
    dec_o.alu_op = ALU_ADD;
    legal        = 1'b0;
    case (opc)
      OPC_LUI: begin
        legal = 1'b1; dec_o.reg_write = 1'b1; dec_o.imm = imm_u; dec_o.alu_op = ALU_COPY_B;
      end
      OPC_AUIPC: begin
        legal = 1'b1; dec_o.reg_write = 1'b1; dec_o.imm = imm_u;
      end
      OPC_JAL: begin
        legal = 1'b1; dec_o.reg_write = 1'b1; dec_o.jump = 1'b1; dec_o.imm = imm_j;
      end
      OPC_JALR: begin
        legal = (f3 == 3'd0); dec_o.reg_write = 1'b1; dec_o.jump = 1'b1;
        dec_o.uses_rs1 = 1'b1; dec_o.imm = imm_i;
      end
      OPC_BRANCH: begin
        legal = (f3[2:1] != 2'b01); dec_o.branch = 1'b1;
        dec_o.uses_rs1 = 1'b1; dec_o.uses_rs2 = 1'b1; dec_o.imm = imm_b;
        dec_o.alu_op = !f3[2] ? ALU_SUB : (f3[1] ? ALU_SLTU : ALU_SLT);
      end
      OPC_LOAD: begin
        legal = (f3 != 3'd3) && (f3 < 3'd6); dec_o.reg_write = 1'b1; dec_o.mem_read = 1'b1;
        dec_o.uses_rs1 = 1'b1; dec_o.imm = imm_i;
      end
      OPC_STORE: begin
        legal = (f3 < 3'd3); dec_o.mem_write = 1'b1;
        dec_o.uses_rs1 = 1'b1; dec_o.uses_rs2 = 1'b1; dec_o.imm = imm_s;
      end
      OPC_OP_IMM: begin
        dec_o.reg_write = 1'b1; dec_o.uses_rs1 = 1'b1; dec_o.imm = imm_i;
        dec_o.alu_op = alu_from_f3(f3, (f3 == 3'd5) && instr_i[30]);
        if (f3 == 3'd1)      legal = (f7 == 7'h00);
        else if (f3 == 3'd5) legal = (f7 == 7'h00) || (f7 == 7'h20);
        else                 legal = 1'b1;
      end
      OPC_OP: begin
        dec_o.reg_write = 1'b1; dec_o.uses_rs1 = 1'b1; dec_o.uses_rs2 = 1'b1;
        if (f7 == 7'h00) begin
          legal = 1'b1; dec_o.alu_op = alu_from_f3(f3, 1'b0);
        end else if (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)) begin
          legal = 1'b1; dec_o.alu_op = alu_from_f3(f3, 1'b1);
        end else if (f7 == 7'h01) begin
`ifdef DECODE_RV32M_EN
          legal = 1'b1; dec_o.alu_op = alu_op_e'({2'b10, f3});
`else
          legal = 1'b0;
`endif
        end
      end
      OPC_MISC_MEM: begin
        legal = (f3 == 3'd0); dec_o.imm = imm_i;
      end
      OPC_SYSTEM: begin
        legal = (f3 != 3'd4); dec_o.is_system = 1'b1; dec_o.imm = imm_i;
        dec_o.uses_rs1  = (f3 != 3'd0) && !f3[2];
        dec_o.reg_write = (f3 != 3'd0);
      end
      default: legal = 1'b0;
    endcase
    if (instr_i[1:0] != 2'b11) legal = 1'b0;
    if (!legal) begin
      dec_o.illegal   = 1'b1;
      dec_o.reg_write = 1'b0;
      dec_o.mem_read  = 1'b0;
      dec_o.mem_write = 1'b0;
      dec_o.branch    = 1'b0;
      dec_o.jump      = 1'b0;
      dec_o.alu_op    = ALU_ADD;
    end
    if (dec_o.rd == 5'd0) dec_o.reg_write = 1'b0;
  end
endmodule

// File: rtl/decode_stage.sv
// Decode stage: IF/ID register, combinational decode, ID/EX register with
// valid/ready handshake, load-use interlock and flush. Build option:
// DECODE_RV32M_EN (decode RV32M multiply/divide ops).
module decode_stage
  import instruction_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          fetch_valid_i,
  input  inst_fetched_t fetch_inst_i,
  output logic          stall_o,
  input  logic          flush_i,
  output logic [4:0]    rs1_addr_o,
  output logic [4:0]    rs2_addr_o,
  output logic          dec_valid_o,
  input  logic          dec_ready_i,
  output decoded_inst_t dec_inst_o
);
  logic          ifid_valid_q;
  inst_fetched_t ifid_inst_q;
  logic          dec_valid_q;
  decoded_inst_t dec_inst_q, dec_inst_d;
  logic          out_free, hazard, advance, ifid_load;

  rv_decoder u_dec (
    .instr_i (ifid_inst_q.instr),
    .pc_i    (ifid_inst_q.pc),
    .dec_o   (dec_inst_d)
  );

  // A load in ID/EX whose rd feeds the instruction in IF/ID must wait one cycle.
  assign hazard = dec_valid_q && dec_inst_q.mem_read && (dec_inst_q.rd != 5'd0) &&
                  ((dec_inst_d.uses_rs1 && dec_inst_d.rs1 == dec_inst_q.rd) ||
                   (dec_inst_d.uses_rs2 && dec_inst_d.rs2 == dec_inst_q.rd));
  assign out_free  = !dec_valid_q || dec_ready_i;
  assign advance   = ifid_valid_q && out_free && !hazard;
  assign ifid_load = !ifid_valid_q || advance;
  assign stall_o   = ifid_valid_q && !advance && !flush_i;

  assign rs1_addr_o  = ifid_inst_q.instr[19:15];
  assign rs2_addr_o  = ifid_inst_q.instr[24:20];
  assign dec_valid_o = dec_valid_q;
  assign dec_inst_o  = dec_inst_q;

  // IF/ID: take the fetched instruction whenever the slot empties; flush kills it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ifid_valid_q <= 1'b0;
      ifid_inst_q  <= '0;
    end else if (flush_i) begin
      ifid_valid_q <= 1'b0;
    end else if (ifid_load) begin
      ifid_valid_q <= fetch_valid_i;
      ifid_inst_q  <= fetch_inst_i;
    end
  end

  // ID/EX: load on advance, drop to a bubble when free, hold under back-pressure.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dec_valid_q <= 1'b0;
      dec_inst_q  <= '0;
    end else if (flush_i) begin
      dec_valid_q <= 1'b0;
    end else if (advance) begin
      dec_valid_q <= 1'b1;
      dec_inst_q  <= dec_inst_d;
    end else if (out_free) begin
      dec_valid_q <= 1'b0;
    end
  end
endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed timing scenarios plus a
// randomized stream scored against a spec-level decode model.
module tb_decode_stage;
  import instruction_pkg::*;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          fetch_valid_i = 1'b0;
  inst_fetched_t fetch_inst_i = '0;
  logic          stall_o;
  logic          flush_i = 1'b0;
  logic [4:0]    rs1_addr_o, rs2_addr_o;
  logic          dec_valid_o;
  logic          dec_ready_i = 1'b1;
  decoded_inst_t dec_inst_o;

  int tests = 0;
  int fails = 0;

  decode_stage dut (
    .clk(clk), .rst(rst), .fetch_valid_i(fetch_valid_i), .fetch_inst_i(fetch_inst_i),
    .stall_o(stall_o), .flush_i(flush_i), .rs1_addr_o(rs1_addr_o), .rs2_addr_o(rs2_addr_o),
    .dec_valid_o(dec_valid_o), .dec_ready_i(dec_ready_i), .dec_inst_o(dec_inst_o)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // ---------------- reference decode model ----------------
  function automatic decoded_inst_t ref_decode(input logic [31:0] pc, input logic [31:0] w);
    decoded_inst_t e;
    logic [2:0] f3;
    logic [6:0] f7;
    bit ok;
    int fmt; // 0 none, 1 I, 2 S, 3 B, 4 U, 5 J
    alu_op_e base[8] = '{ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_OR, ALU_AND};
    alu_op_e mext[8] = '{ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU, ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU};
    e = '0; f3 = w[14:12]; f7 = w[31:25]; ok = 0; fmt = 0;
    e.pc = pc; e.rd = w[11:7]; e.rs1 = w[19:15]; e.rs2 = w[24:20]; e.funct3 = f3; e.alu_op = ALU_ADD;
    case (w[6:0])
      7'h37: begin ok = 1; fmt = 4; e.reg_write = 1; e.alu_op = ALU_COPY_B; end
      7'h17: begin ok = 1; fmt = 4; e.reg_write = 1; end
      7'h6F: begin ok = 1; fmt = 5; e.reg_write = 1; e.jump = 1; end
      7'h67: begin ok = (f3 == 0); fmt = 1; e.reg_write = 1; e.jump = 1; e.uses_rs1 = 1; end
      7'h63: begin
        ok = !(f3 == 2 || f3 == 3); fmt = 3; e.branch = 1; e.uses_rs1 = 1; e.uses_rs2 = 1;
        e.alu_op = (f3 < 2) ? ALU_SUB : (f3 < 6) ? ALU_SLT : ALU_SLTU;
      end
      7'h03: begin ok = (f3 inside {0, 1, 2, 4, 5}); fmt = 1; e.reg_write = 1; e.mem_read = 1; e.uses_rs1 = 1; end
      7'h23: begin ok = (f3 inside {0, 1, 2}); fmt = 2; e.mem_write = 1; e.uses_rs1 = 1; e.uses_rs2 = 1; end
      7'h13: begin
        fmt = 1; e.reg_write = 1; e.uses_rs1 = 1;
        if (f3 == 1) begin ok = (f7 == 0); e.alu_op = ALU_SLL; end
        else if (f3 == 5) begin ok = (f7 == 0 || f7 == 7'h20); e.alu_op = (f7 == 7'h20) ? ALU_SRA : ALU_SRL; end
        else begin ok = 1; e.alu_op = base[f3]; end
      end
      7'h33: begin
        e.reg_write = 1; e.uses_rs1 = 1; e.uses_rs2 = 1;
        if (f7 == 0) begin ok = 1; e.alu_op = base[f3]; end
        else if (f7 == 7'h20 && (f3 == 0 || f3 == 5)) begin ok = 1; e.alu_op = (f3 == 0) ? ALU_SUB : ALU_SRA; end
`ifdef DECODE_RV32M_EN
        else if (f7 == 7'h01) begin ok = 1; e.alu_op = mext[f3]; end
`endif
      end
      7'h0F: begin ok = (f3 == 0); fmt = 1; end
      7'h73: begin
        ok = (f3 != 4); fmt = 1; e.is_system = 1;
        e.uses_rs1 = (f3 inside {1, 2, 3}); e.reg_write = (f3 != 0);
      end
      default: ok = 0;
    endcase
    case (fmt)
      1: e.imm = 32'($signed(w) >>> 20);
      2: e.imm = (32'($signed(w) >>> 25) << 5) | 32'(w[11:7]);
      3: e.imm = (32'($signed(w) >>> 31) << 12) | (32'(w[7]) << 11) | (32'(w[30:25]) << 5) | (32'(w[11:8]) << 1);
      4: e.imm = w & 32'hFFFF_F000;
      5: e.imm = (32'($signed(w) >>> 31) << 20) | (32'(w[19:12]) << 12) | (32'(w[20]) << 11) | (32'(w[30:21]) << 1);
      default: e.imm = '0;
    endcase
    if (w[1:0] != 2'b11) ok = 0;
    if (!ok) begin
      e.illegal = 1; e.reg_write = 0; e.mem_read = 0; e.mem_write = 0;
      e.branch = 0; e.jump = 0; e.alu_op = ALU_ADD;
    end
    if (e.rd == 0) e.reg_write = 0;
    return e;
  endfunction

  function automatic logic [31:0] gen_instr();
    logic [31:0] r, res;
    logic [4:0]  rd, s1, s2;
    logic [6:0]  f7;
    r  = $urandom;
    rd = 5'($urandom_range(0, 3));
    s1 = 5'($urandom_range(0, 3));
    s2 = 5'($urandom_range(0, 3));
    case ($urandom_range(0, 3))
      0: f7 = 7'h00;
      1: f7 = 7'h20;
      2: f7 = 7'h01;
      default: f7 = r[31:25];
    endcase
    case ($urandom_range(0, 11))
      0, 1:    res = {r[31:20], s1, r[14:12], rd, 7'h03};
      2:       res = {r[31:25], s2, s1, r[14:12], r[11:7], 7'h23};
      3, 4:    res = {f7, s2, s1, r[14:12], rd, 7'h33};
      5:       res = {f7, r[24:20], s1, r[14:12], rd, 7'h13};
      6:       res = {r[31:25], s2, s1, r[14:12], r[11:7], 7'h63};
      7:       res = {r[31:12], rd, 7'h6F};
      8:       res = {r[31:20], s1, r[14:12], rd, 7'h67};
      9:       res = {r[31:12], rd, r[0] ? 7'h37 : 7'h17};
      10:      res = {r[31:20], s1, r[14:12], rd, r[1] ? 7'h73 : 7'h0F};
      default: res = r;
    endcase
    return res;
  endfunction

  // ---------------- fetch/execute driver ----------------
  logic [31:0]   feed_instr[$], feed_pc[$];
  bit            rdy_q[$];
  bit            gap_mode = 0;
  bit            obs_valid[$], obs_stall[$], obs_ready[$];
  logic [4:0]    obs_rs1[$], obs_rs2[$];
  decoded_inst_t obs_inst[$], outs[$];

  task automatic clear_obs();
    obs_valid.delete(); obs_stall.delete(); obs_ready.delete();
    obs_rs1.delete(); obs_rs2.delete(); obs_inst.delete(); outs.delete();
  endtask

  // Acts as fetch (holds while stalled) and execute (ready from rdy_q, else 1).
  // Called and returns at 1 time unit after a rising edge.
  task automatic run_cycles(input int ncyc);
    bit acc;
    bit prev_stall = 0;
    for (int c = 0; c < ncyc; c++) begin
      fetch_valid_i = (feed_instr.size() > 0) && !(gap_mode && !prev_stall && $urandom_range(0, 3) == 0);
      if (feed_instr.size() > 0) begin
        fetch_inst_i.pc    = feed_pc[0];
        fetch_inst_i.instr = feed_instr[0];
      end
      dec_ready_i = (rdy_q.size() > 0) ? rdy_q.pop_front() : 1'b1;
      @(negedge clk);
      obs_valid.push_back(dec_valid_o); obs_stall.push_back(stall_o); obs_ready.push_back(dec_ready_i);
      obs_rs1.push_back(rs1_addr_o); obs_rs2.push_back(rs2_addr_o); obs_inst.push_back(dec_inst_o);
      if (dec_valid_o && dec_ready_i) outs.push_back(dec_inst_o);
      acc = fetch_valid_i && !stall_o;
      prev_stall = stall_o;
      @(posedge clk); #1;
      if (acc) begin void'(feed_instr.pop_front()); void'(feed_pc.pop_front()); end
    end
    fetch_valid_i = 1'b0;
    dec_ready_i   = 1'b1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    @(negedge clk);
    tests++; if (dec_valid_o !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b expected 0", dec_valid_o); end
    tests++; if (stall_o !== 1'b0) begin fails++; $display("FAIL reset_stall: got %b expected 0", stall_o); end
    tests++; if (dec_inst_o !== '0) begin fails++; $display("FAIL reset_inst: got %h expected 0", dec_inst_o); end
    tests++; if (rs1_addr_o !== 5'd0 || rs2_addr_o !== 5'd0) begin fails++; $display("FAIL reset_rs: got %0d/%0d expected 0/0", rs1_addr_o, rs2_addr_o); end
    @(posedge clk); #1; rst = 1'b0;
  endtask

  task automatic test_addi();
    clear_obs();
    feed_instr.push_back(32'h00500093); feed_pc.push_back(32'h100);
    run_cycles(4);
    tests++; if (obs_valid[1] !== 1'b0) begin fails++; $display("FAIL addi_early: valid one edge after accept got %b expected 0", obs_valid[1]); end
    tests++; if (obs_rs1[1] !== 5'd0) begin fails++; $display("FAIL addi_rs1_addr: got %0d expected 0", obs_rs1[1]); end
    tests++; if (obs_valid[2] !== 1'b1) begin fails++; $display("FAIL addi_valid: got %b expected 1", obs_valid[2]); end
    tests++; if (obs_inst[2].rd !== 5'd1 || obs_inst[2].rs1 !== 5'd0 || obs_inst[2].imm !== 32'd5)
      begin fails++; $display("FAIL addi_fields: rd=%0d rs1=%0d imm=%h expected 1/0/5", obs_inst[2].rd, obs_inst[2].rs1, obs_inst[2].imm); end
    tests++; if (obs_inst[2].alu_op !== ALU_ADD || obs_inst[2].reg_write !== 1'b1 || obs_inst[2].pc !== 32'h100)
      begin fails++; $display("FAIL addi_ctrl: alu=%0d rw=%b pc=%h expected ADD/1/100", obs_inst[2].alu_op, obs_inst[2].reg_write, obs_inst[2].pc); end
    tests++; if (obs_valid[3] !== 1'b0) begin fails++; $display("FAIL addi_single: got %b expected 0", obs_valid[3]); end
  endtask

  task automatic test_load_use();
    int nstall = 0;
    clear_obs();
    feed_instr.push_back(32'h0000A103); feed_pc.push_back(32'h200);
    feed_instr.push_back(32'h002101B3); feed_pc.push_back(32'h204);
    run_cycles(6);
    foreach (obs_stall[i]) nstall += obs_stall[i];
    tests++; if (nstall != 1) begin fails++; $display("FAIL lu_stall_count: got %0d expected 1", nstall); end
    tests++; if (obs_stall[2] !== 1'b1) begin fails++; $display("FAIL lu_stall_cycle: got %b expected 1", obs_stall[2]); end
    tests++; if (obs_rs1[2] !== 5'd2 || obs_rs2[2] !== 5'd2) begin fails++; $display("FAIL lu_rs_addr: got %0d/%0d expected 2/2", obs_rs1[2], obs_rs2[2]); end
    tests++; if (obs_valid[2] !== 1'b1 || obs_inst[2].pc !== 32'h200) begin fails++; $display("FAIL lu_lw: valid=%b pc=%h expected 1/200", obs_valid[2], obs_inst[2].pc); end
    tests++; if (obs_valid[3] !== 1'b0) begin fails++; $display("FAIL lu_bubble: got %b expected 0", obs_valid[3]); end
    tests++; if (obs_valid[4] !== 1'b1 || obs_inst[4] !== ref_decode(32'h204, 32'h002101B3))
      begin fails++; $display("FAIL lu_add: valid=%b got %h expected %h", obs_valid[4], obs_inst[4], ref_decode(32'h204, 32'h002101B3)); end
  endtask

  task automatic test_back_pressure();
    clear_obs();
    for (int i = 0; i < 4; i++) begin
      feed_instr.push_back({12'(i), 5'd0, 3'd0, 5'(i + 1), 7'h13});
      feed_pc.push_back(32'h300 + 32'(4 * i));
    end
    rdy_q = '{1, 1, 1, 0, 0, 0};
    run_cycles(12);
    for (int c = 3; c <= 5; c++) begin
      tests++; if (obs_stall[c] !== 1'b1) begin fails++; $display("FAIL bp_stall[%0d]: got %b expected 1", c, obs_stall[c]); end
      tests++; if (obs_valid[c+1] !== 1'b1 || obs_inst[c+1] !== obs_inst[c] || obs_inst[c].pc !== 32'h304)
        begin fails++; $display("FAIL bp_hold[%0d]: pc=%h next=%h expected 304 stable", c, obs_inst[c].pc, obs_inst[c+1].pc); end
    end
    tests++; if (outs.size() != 4) begin fails++; $display("FAIL bp_count: got %0d expected 4", outs.size()); end
    for (int i = 0; i < outs.size() && i < 4; i++) begin
      tests++; if (outs[i].pc !== 32'h300 + 32'(4 * i)) begin fails++; $display("FAIL bp_order[%0d]: pc %h expected %h", i, outs[i].pc, 32'h300 + 32'(4 * i)); end
    end
  endtask

  task automatic test_flush();
    fetch_valid_i = 1'b1; dec_ready_i = 1'b0;
    fetch_inst_i.pc = 32'h500; fetch_inst_i.instr = 32'h00100093;
    @(posedge clk); #1;
    fetch_inst_i.pc = 32'h504; fetch_inst_i.instr = 32'h00200113;
    @(posedge clk); #1;
    fetch_inst_i.pc = 32'h508; fetch_inst_i.instr = 32'h00300193;
    flush_i = 1'b1;
    @(negedge clk);
    tests++; if (dec_valid_o !== 1'b1 || stall_o !== 1'b0) begin fails++; $display("FAIL flush_pre: valid=%b stall=%b expected 1/0", dec_valid_o, stall_o); end
    @(posedge clk); #1; flush_i = 1'b0;
    @(negedge clk);
    tests++; if (dec_valid_o !== 1'b0 || stall_o !== 1'b0) begin fails++; $display("FAIL flush_clear: valid=%b stall=%b expected 0/0", dec_valid_o, stall_o); end
    @(posedge clk); #1; fetch_valid_i = 1'b0; dec_ready_i = 1'b1;
    @(negedge clk);
    tests++; if (dec_valid_o !== 1'b0) begin fails++; $display("FAIL flush_gap: got %b expected 0", dec_valid_o); end
    @(posedge clk); #1;
    @(negedge clk);
    tests++; if (dec_valid_o !== 1'b1 || dec_inst_o.pc !== 32'h508) begin fails++; $display("FAIL flush_refetch: valid=%b pc=%h expected 1/508", dec_valid_o, dec_inst_o.pc); end
    @(posedge clk); #1;
  endtask

  task automatic test_illegal_mul();
    clear_obs();
    feed_instr.push_back(32'hFFFFFFFF); feed_pc.push_back(32'h400);
    feed_instr.push_back(32'h027302B3); feed_pc.push_back(32'h404);
    run_cycles(6);
    tests++; if (outs.size() != 2) begin fails++; $display("FAIL ill_count: got %0d expected 2", outs.size()); end
    else begin
      tests++; if (outs[0].illegal !== 1'b1 || outs[0].reg_write !== 1'b0 || outs[0].mem_write !== 1'b0 || outs[0].pc !== 32'h400)
        begin fails++; $display("FAIL ill_fields: ill=%b rw=%b mw=%b pc=%h expected 1/0/0/400", outs[0].illegal, outs[0].reg_write, outs[0].mem_write, outs[0].pc); end
`ifdef DECODE_RV32M_EN
      tests++; if (outs[1].alu_op !== ALU_MUL || outs[1].illegal !== 1'b0 || outs[1].reg_write !== 1'b1)
        begin fails++; $display("FAIL mul: alu=%0d ill=%b rw=%b expected MUL/0/1", outs[1].alu_op, outs[1].illegal, outs[1].reg_write); end
`else
      tests++; if (outs[1].illegal !== 1'b1 || outs[1].reg_write !== 1'b0)
        begin fails++; $display("FAIL mul: ill=%b rw=%b expected 1/0", outs[1].illegal, outs[1].reg_write); end
`endif
    end
  endtask

  task automatic test_random_stream();
    decoded_inst_t exp[$];
    logic [31:0] w;
    int n = 150;
    clear_obs();
    gap_mode = 1;
    for (int i = 0; i < n; i++) begin
      w = gen_instr();
      feed_instr.push_back(w); feed_pc.push_back(32'h1000 + 32'(4 * i));
      exp.push_back(ref_decode(32'h1000 + 32'(4 * i), w));
    end
    for (int i = 0; i < 400; i++) rdy_q.push_back($urandom_range(0, 9) < 7);
    run_cycles(1500);
    gap_mode = 0;
    tests++; if (outs.size() != n) begin fails++; $display("FAIL rnd_count: got %0d expected %0d", outs.size(), n); end
    for (int i = 0; i < outs.size() && i < n; i++) begin
      tests++; if (outs[i] !== exp[i]) begin fails++; $display("FAIL rnd_out[%0d]: got %h expected %h", i, outs[i], exp[i]); end
    end
    for (int c = 0; c + 1 < obs_valid.size(); c++) begin
      if (obs_valid[c] && !obs_ready[c]) begin
        tests++; if (!obs_valid[c+1] || obs_inst[c+1] !== obs_inst[c])
          begin fails++; $display("FAIL rnd_hold[%0d]: got %h expected %h", c, obs_inst[c+1], obs_inst[c]); end
      end
    end
    feed_instr.delete(); feed_pc.delete(); rdy_q.delete();
  endtask

  task automatic test_reset_mid();
    clear_obs();
    for (int i = 0; i < 3; i++) begin
      feed_instr.push_back(32'h0000A103); feed_pc.push_back(32'h600 + 32'(4 * i));
    end
    rdy_q = '{0, 0, 0};
    run_cycles(3);
    rst = 1'b1;
    #1;
    tests++; if (dec_valid_o !== 1'b0 || stall_o !== 1'b0) begin fails++; $display("FAIL rstmid_ctrl: valid=%b stall=%b expected 0/0", dec_valid_o, stall_o); end
    tests++; if (dec_inst_o !== '0 || rs1_addr_o !== 5'd0) begin fails++; $display("FAIL rstmid_data: inst=%h rs1=%0d expected 0/0", dec_inst_o, rs1_addr_o); end
    feed_instr.delete(); feed_pc.delete(); rdy_q.delete();
    @(posedge clk); #1; rst = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    test_reset();
    test_addi();
    test_load_use();
    test_back_pressure();
    test_flush();
    test_illegal_mul();
    test_random_stream();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
